// File: rtl/pc_defs.sv
// Shared definitions for the fetch-stage PC unit: next-PC op encodings and default addresses.
package pc_defs;

  typedef enum logic [1:0] {
    NPC_SEQ = 2'b00,
    NPC_J   = 2'b01,
    NPC_BR  = 2'b10,
    NPC_JR  = 2'b11
  } npc_op_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational redirect target for J/JAL, conditional branch and JR/JALR, plus an effective
// flag that is low for SEQ and for an untaken branch.
module npc_target_calc
  import pc_defs::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [1:0]        npc_op,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [25:0]       instr_index,
  input  logic [15:0]       imm16,
  input  logic [ADDR_W-1:0] rs_val,
  output logic [ADDR_W-1:0] target,
  output logic              effective
);

  // Bits above the 256 MB jump region are kept from the delay-slot PC.
  localparam logic [ADDR_W-1:0] RegionMask = ~ADDR_W'(28'hFFF_FFFF);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] j_tgt;

  assign pc_plus4 = pc_d + ADDR_W'(4);
  assign br_off   = {{(ADDR_W - 18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt    = (pc_plus4 & RegionMask) | ADDR_W'({instr_index, 2'b00});

  always_comb begin
    target    = pc_plus4;
    effective = 1'b0;
    unique case (npc_op_e'(npc_op))
      NPC_SEQ: begin
        target    = pc_plus4;
        effective = 1'b0;
      end
      NPC_J: begin
        target    = j_tgt;
        effective = 1'b1;
      end
      NPC_BR: begin
        target    = pc_plus4 + br_off;
        effective = br_taken;
      end
      NPC_JR: begin
        target    = rs_val;
        effective = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with stall hold, one-deep pending-redirect buffer and address-error flag.
// Optional exception/eret redirect enabled by defining PC_EXC_EN.
module pc_redirect_unit
  import pc_defs::*;
#(
  parameter int unsigned     ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [1:0]        npc_op,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] pc_d,
  input  logic [25:0]       instr_index,
  input  logic [15:0]       imm16,
  input  logic [ADDR_W-1:0] rs_val,
`ifdef PC_EXC_EN
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
`endif
  output logic [ADDR_W-1:0] pc_f,
  output logic [ADDR_W-1:0] pc4_f,
  output logic              redirect_pending,
  output logic              addr_err
);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;
  logic [ADDR_W-1:0] tgt;
  logic              tgt_eff;

  npc_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_npc_target_calc (
    .npc_op     (npc_op),
    .br_taken   (br_taken),
    .pc_d       (pc_d),
    .instr_index(instr_index),
    .imm16      (imm16),
    .rs_val     (rs_val),
    .target     (tgt),
    .effective  (tgt_eff)
  );

`ifndef PC_EXC_EN
  logic unused_exc_vec;
  assign unused_exc_vec = ^EXC_VEC;
`endif

  always_comb begin
    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
`ifdef PC_EXC_EN
    if (exc_req) begin
      fetch_pc_d = EXC_VEC;
      pend_d     = 1'b0;
    end else if (eret_req) begin
      fetch_pc_d = epc;
      pend_d     = 1'b0;
    end else
`endif
    if (stall) begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid && tgt_eff) begin
        pend_d     = 1'b1;
        pend_tgt_d = tgt;
      end
    end else if (redirect_valid && tgt_eff) begin
      // A live redirect is younger than anything buffered, so it wins.
      fetch_pc_d = tgt;
      pend_d     = 1'b0;
    end else if (pend_q) begin
      fetch_pc_d = pend_tgt_q;
      pend_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fetch_pc_q <= RESET_PC;
      pend_q     <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_f             = fetch_pc_q;
  assign pc4_f            = fetch_pc_q + ADDR_W'(4);
  assign redirect_pending = pend_q;
  assign addr_err         = |fetch_pc_q[1:0];

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed and randomized bench for pc_redirect_unit against an arithmetic reference model.
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br_taken = 1'b0;
  logic [31:0] pc_d = '0;
  logic [25:0] instr_index = '0;
  logic [15:0] imm16 = '0;
  logic [31:0] rs_val = '0;
`ifdef PC_EXC_EN
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = '0;
`endif
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic        redirect_pending;
  logic        addr_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc = 32'h0;
  logic        m_pend = 1'b0;
  logic [31:0] m_ptgt = 32'h0;

  pc_redirect_unit #(
    .ADDR_W  (32),
    .RESET_PC(32'h0000_3000),
    .EXC_VEC (32'h0000_4180)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .npc_op          (npc_op),
    .br_taken        (br_taken),
    .pc_d            (pc_d),
    .instr_index     (instr_index),
    .imm16           (imm16),
    .rs_val          (rs_val),
`ifdef PC_EXC_EN
    .exc_req         (exc_req),
    .eret_req        (eret_req),
    .epc             (epc),
`endif
    .pc_f            (pc_f),
    .pc4_f           (pc4_f),
    .redirect_pending(redirect_pending),
    .addr_err        (addr_err)
  );

  always #5 clk = ~clk;

  // Target per instruction class, computed directly from the ISA rules.
  function automatic logic [31:0] ref_target();
    logic [31:0] t;
    case (npc_op)
      2'd1:    t = ((pc_d + 32'd4) & 32'hF000_0000) + ({6'b0, instr_index} * 32'd4);
      2'd2:    t = pc_d + 32'd4 + (32'($signed(imm16)) * 32'd4);
      2'd3:    t = rs_val;
      default: t = pc_d + 32'd4;
    endcase
    return t;
  endfunction

  function automatic bit ref_effective();
    return redirect_valid && (npc_op == 2'd1 || npc_op == 2'd3 || (npc_op == 2'd2 && br_taken));
  endfunction

  task automatic model_update();
    bit exc = 1'b0;
    bit eret = 1'b0;
    logic [31:0] ev = 32'h0;
`ifdef PC_EXC_EN
    exc  = exc_req;
    eret = eret_req;
    ev   = epc;
`endif
    if (!reset_n) begin
      m_pc = 32'h0000_3000; m_pend = 1'b0; m_ptgt = 32'h0;
    end else if (exc) begin
      m_pc = 32'h0000_4180; m_pend = 1'b0;
    end else if (eret) begin
      m_pc = ev; m_pend = 1'b0;
    end else if (stall) begin
      if (ref_effective()) begin
        m_pend = 1'b1; m_ptgt = ref_target();
      end
    end else if (ref_effective()) begin
      m_pc = ref_target(); m_pend = 1'b0;
    end else if (m_pend) begin
      m_pc = m_ptgt; m_pend = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc_f"}, pc_f, m_pc);
    check({tag, ".pc4_f"}, pc4_f, m_pc + 32'd4);
    check({tag, ".pending"}, 32'(redirect_pending), 32'(m_pend));
    check({tag, ".addr_err"}, 32'(addr_err), 32'(m_pc[1:0] != 2'b00));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_update();
    #1;
    check_model(tag);
  endtask

  task automatic set_br(input logic taken);
    redirect_valid = 1'b1; npc_op = 2'd2; pc_d = 32'h3010; imm16 = 16'hFFFC; br_taken = taken;
  endtask

  task automatic set_j();
    redirect_valid = 1'b1; npc_op = 2'd1; pc_d = 32'h3020; instr_index = 26'h0000C40;
  endtask

  initial begin
    // Reset and sequential fetch
    reset_n = 1'b0;
    step("reset");
    check("reset_pc", pc_f, 32'h3000);
    check("reset_pending", 32'(redirect_pending), 32'd0);
    reset_n = 1'b1;
    step("seq1");
    check("seq1_pc", pc_f, 32'h3004);
    step("seq2");
    check("seq2_pc", pc_f, 32'h3008);

    // Taken backward branch, then untaken
    set_br(1'b1);
    step("br_taken");
    check("br_taken_pc", pc_f, 32'h3004);
    redirect_valid = 1'b0;
    step("after_br");
    set_br(1'b0);
    step("br_untaken");
    check("br_untaken_pc", pc_f, 32'h300C);

    // Jump and misaligned register jump
    set_j();
    step("j");
    check("j_pc", pc_f, 32'h3100);
    redirect_valid = 1'b1; npc_op = 2'd3; rs_val = 32'h3402;
    step("jr");
    check("jr_pc", pc_f, 32'h3402);
    check("jr_addr_err", 32'(addr_err), 32'd1);

    // Redirect arriving during a 3-cycle stall
    stall = 1'b1; set_j();
    step("stall1");
    redirect_valid = 1'b0;
    step("stall2");
    step("stall3");
    check("stall_hold_pc", pc_f, 32'h3402);
    check("stall_pending", 32'(redirect_pending), 32'd1);
    stall = 1'b0;
    step("stall_release");
    check("release_pc", pc_f, 32'h3100);
    check("release_pending", 32'(redirect_pending), 32'd0);

    // Live branch beats a buffered jump on the release cycle
    stall = 1'b1; set_j();
    step("pend_buf");
    stall = 1'b0; set_br(1'b1);
    step("live_wins");
    check("live_wins_pc", pc_f, 32'h3004);
    check("live_wins_pending", 32'(redirect_pending), 32'd0);
    redirect_valid = 1'b0;
    step("after_live");

    // Reset while a redirect is pending
    stall = 1'b1; set_j();
    step("pend_again");
    redirect_valid = 1'b0; reset_n = 1'b0;
    step("reset_pending");
    check("rst_pend_pc", pc_f, 32'h3000);
    check("rst_pend_flag", 32'(redirect_pending), 32'd0);
    reset_n = 1'b1; stall = 1'b0;
    step("post_reset");

`ifdef PC_EXC_EN
    stall = 1'b1; set_j(); exc_req = 1'b1;
    step("exc");
    check("exc_pc", pc_f, 32'h4180);
    exc_req = 1'b0; redirect_valid = 1'b0; stall = 1'b0; eret_req = 1'b1; epc = 32'h3040;
    step("eret");
    check("eret_pc", pc_f, 32'h3040);
    eret_req = 1'b0;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset_n        = ($urandom_range(0, 39) != 0);
      stall          = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 2) == 0);
      npc_op         = 2'($urandom_range(0, 3));
      br_taken       = 1'($urandom);
      pc_d           = $urandom & 32'hFFFF_FFFC;
      instr_index    = 26'($urandom);
      imm16          = 16'($urandom);
      rs_val         = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
`ifdef PC_EXC_EN
      exc_req        = ($urandom_range(0, 19) == 0);
      eret_req       = ($urandom_range(0, 19) == 0);
      epc            = $urandom & 32'hFFFF_FFFC;
`endif
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
